// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction field
// positions (MSB-first numbering) and sequencer state encodings.
package instr_sequencer_pkg;

   typedef logic [0:7] instr_t;

   typedef enum logic [1:0] {
      OP_MOV_TO_R0   = 2'b00,
      OP_MOV_FROM_R0 = 2'b01,
      OP_LOAD_IMM    = 2'b10,
      OP_ALU         = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   localparam int OPC_MSB = 0;
   localparam int OPC_LSB = 1;
   localparam int REG_MSB = 2;
   localparam int REG_LSB = 3;
   localparam int IMM_MSB = 4;
   localparam int IMM_LSB = 7;

   function automatic opcode_e opcode_of(input instr_t i);
      return opcode_e'(i[OPC_MSB:OPC_LSB]);
   endfunction

   function automatic logic [1:0] reg_of(input instr_t i);
      return i[REG_MSB:REG_LSB];
   endfunction

   function automatic logic [3:0] imm_of(input instr_t i);
      return i[IMM_MSB:IMM_LSB];
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction bus between the sequencer (master) and the processor core (slave).
interface instr_sequencer_if;
   import instr_sequencer_pkg::*;

   instr_t sig_out;
   logic   sig_valid;
   logic   sig_ready;

   modport master (output sig_out, output sig_valid, input sig_ready);
   modport slave  (input sig_out, input sig_valid, output sig_ready);
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program buffer: DEPTH x 8 RAM with synchronous write and registered read.
// The read register clears on reset; the array contents do not.
module seq_prog_mem
   import instr_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  instr_t        wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output instr_t        rdata
);

   instr_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a small program and issues it one word per
// valid/ready transfer, with an optional bubble after each ALU instruction.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int GAP_ALU = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld_en,
   input  logic [AW-1:0]       ld_addr,
   input  instr_t              ld_data,
   input  logic [AW:0]         prog_len,
   input  logic                loop_mode,
   input  logic                start,
   input  logic                stop,
   instr_sequencer_if.master   bus,
   output logic                busy,
   output logic                done,
   output logic [AW-1:0]       pc,
   output logic [15:0]         issue_cnt
);

   seq_state_e    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          valid_q, valid_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [7:0]    gap_q, gap_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [AW:0]   len;
   logic          last, transfer, zero_start, adv_end, mem_we, mem_re;
   logic [AW-1:0] adv_pc;
   instr_t        rdata;

   assign len      = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
   assign last     = ({1'b0, pc_q} == (len - 1'b1));
   assign transfer = valid_q & bus.sig_ready;
   assign adv_end  = last & ~loop_mode;
   assign adv_pc   = last ? '0 : pc_q + 1'b1;
   assign mem_we   = ld_en & (state_q != ST_ISSUE) & (state_q != ST_GAP);
   // Reading at the next pc makes the word land in the same cycle as sig_valid.
   assign mem_re   = (state_d == ST_ISSUE);

   seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (ld_addr),
      .wdata (ld_data),
      .re    (mem_re),
      .raddr (pc_d),
      .rdata (rdata)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      zero_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               if (len == '0) begin
                  zero_start = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
                  pc_d    = '0;
                  cnt_d   = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (stop) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               pc_d    = '0;
            end else if (!valid_q) begin
               // First cycle after start: word 0 is being fetched.
               valid_d = 1'b1;
            end else if (transfer) begin
               cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
               if ((opcode_of(rdata) == OP_ALU) && (GAP_ALU > 0)) begin
                  state_d = ST_GAP;
                  valid_d = 1'b0;
                  gap_d   = 8'(GAP_ALU - 1);
               end else if (adv_end) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  pc_d    = '0;
               end else begin
                  pc_d = adv_pc;
               end
            end
         end
         ST_GAP: begin
            if (stop) begin
               state_d = ST_IDLE;
               pc_d    = '0;
            end else if (gap_q != 8'd0) begin
               gap_d = gap_q - 8'd1;
            end else if (adv_end) begin
               state_d = ST_DONE;
               pc_d    = '0;
            end else begin
               state_d = ST_ISSUE;
               valid_d = 1'b1;
               pc_d    = adv_pc;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_ISSUE) || (state_d == ST_GAP);
      done_d = (state_d == ST_DONE) || zero_start;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.sig_out   = rdata;
   assign bus.sig_valid = valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pc            = pc_q;
   assign issue_cnt     = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: inputs change and outputs are sampled
// on the falling edge; expected values are hand-derived constants.
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_en = 1'b0;
   logic [3:0]  ld_addr = '0;
   instr_t      ld_data = '0;
   logic [4:0]  prog_len = '0;
   logic        loop_mode = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        busy, done;
   logic [3:0]  pc;
   logic [15:0] issue_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   instr_sequencer_if bus_if ();

   instr_sequencer #(.DEPTH(16), .AW(4), .GAP_ALU(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .prog_len  (prog_len),
      .loop_mode (loop_mode),
      .start     (start),
      .stop      (stop),
      .bus       (bus_if.master),
      .busy      (busy),
      .done      (done),
      .pc        (pc),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   task automatic write_word(input logic [3:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      $display("load   mem[%0d] <= %h", a, d);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      bus_if.sig_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if ({bus_if.sig_out, bus_if.sig_valid, busy, done, pc, issue_cnt} !== 31'd0) begin
         $display("FAIL reset: out=%h v=%b busy=%b done=%b pc=%0d cnt=%0d required all zero",
                  bus_if.sig_out, bus_if.sig_valid, busy, done, pc, issue_cnt);
         err_cnt++;
      end
      $display("reset  out=%h valid=%b busy=%b", bus_if.sig_out, bus_if.sig_valid, busy);
   endtask

   task automatic test_linear();
      logic [7:0] w [3];
      w[0] = 8'h81; w[1] = 8'h42; w[2] = 8'h1C;
      for (int i = 0; i < 3; i++) write_word(4'(i), w[i]);
      prog_len = 5'd3; loop_mode = 1'b0; bus_if.sig_ready = 1'b1;
      pulse_start();
      vec_cnt++;
      if (bus_if.sig_valid !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL linear_latency: valid=%b busy=%b required valid=0 busy=1", bus_if.sig_valid, busy);
         err_cnt++;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (bus_if.sig_valid !== 1'b1 || bus_if.sig_out !== w[i] || pc !== 4'(i)) begin
            $display("FAIL linear_word%0d: valid=%b out=%h pc=%0d required 1 %h %0d",
                     i, bus_if.sig_valid, bus_if.sig_out, pc, w[i], i);
            err_cnt++;
         end
         $display("issue  pc=%0d out=%h valid=%b", pc, bus_if.sig_out, bus_if.sig_valid);
      end
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b1 || bus_if.sig_valid !== 1'b0 || busy !== 1'b0 || issue_cnt !== 16'd3) begin
         $display("FAIL linear_done: done=%b valid=%b busy=%b cnt=%0d required 1 0 0 3",
                  done, bus_if.sig_valid, busy, issue_cnt);
         err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b0) begin
         $display("FAIL linear_done_once: done=%b required 0", done);
         err_cnt++;
      end
      $display("linear done cnt=%0d", issue_cnt);
   endtask

   task automatic test_alu_gap();
      write_word(4'd0, 8'hC4);
      write_word(4'd1, 8'h40);
      prog_len = 5'd2; bus_if.sig_ready = 1'b1;
      pulse_start();
      @(negedge clk);
      vec_cnt++;
      if (bus_if.sig_valid !== 1'b1 || bus_if.sig_out !== 8'hC4) begin
         $display("FAIL alu_first: valid=%b out=%h required 1 c4", bus_if.sig_valid, bus_if.sig_out);
         err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (bus_if.sig_valid !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL alu_bubble: valid=%b busy=%b required 0 1", bus_if.sig_valid, busy);
         err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (bus_if.sig_valid !== 1'b1 || bus_if.sig_out !== 8'h40 || pc !== 4'd1) begin
         $display("FAIL alu_second: valid=%b out=%h pc=%0d required 1 40 1",
                  bus_if.sig_valid, bus_if.sig_out, pc);
         err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b1 || issue_cnt !== 16'd2) begin
         $display("FAIL alu_done: done=%b cnt=%0d required 1 2", done, issue_cnt);
         err_cnt++;
      end
      $display("alu    done=%b cnt=%0d", done, issue_cnt);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      write_word(4'd0, 8'h81);
      write_word(4'd1, 8'h42);
      prog_len = 5'd2; bus_if.sig_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vec_cnt++;
         if (bus_if.sig_valid !== 1'b1 || bus_if.sig_out !== 8'h81 || issue_cnt !== 16'd0) begin
            $display("FAIL hold_cycle%0d: valid=%b out=%h cnt=%0d required 1 81 0",
                     i, bus_if.sig_valid, bus_if.sig_out, issue_cnt);
            err_cnt++;
         end
         $display("hold   cycle=%0d out=%h valid=%b", i, bus_if.sig_out, bus_if.sig_valid);
      end
      bus_if.sig_ready = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (bus_if.sig_out !== 8'h42 || pc !== 4'd1 || issue_cnt !== 16'd1) begin
         $display("FAIL hold_release: out=%h pc=%0d cnt=%0d required 42 1 1", bus_if.sig_out, pc, issue_cnt);
         err_cnt++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_loop();
      logic [7:0] exp_w;
      prog_len = 5'd2; loop_mode = 1'b1; bus_if.sig_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         exp_w = (i % 2 == 1) ? 8'h42 : 8'h81;
         vec_cnt++;
         if (bus_if.sig_valid !== 1'b1 || bus_if.sig_out !== exp_w || done !== 1'b0) begin
            $display("FAIL loop_word%0d: valid=%b out=%h done=%b required 1 %h 0",
                     i, bus_if.sig_valid, bus_if.sig_out, done, exp_w);
            err_cnt++;
         end
         $display("loop   n=%0d pc=%0d out=%h", i, pc, bus_if.sig_out);
      end
      @(negedge clk);
      vec_cnt++;
      if (issue_cnt !== 16'd7 || done !== 1'b0) begin
         $display("FAIL loop_count: cnt=%0d done=%b required 7 0", issue_cnt, done);
         err_cnt++;
      end
      bus_if.sig_ready = 1'b0; stop = 1'b1; loop_mode = 1'b0;
      @(negedge clk);
      stop = 1'b0;
      vec_cnt++;
      if (busy !== 1'b0 || bus_if.sig_valid !== 1'b0) begin
         $display("FAIL loop_stop: busy=%b valid=%b required 0 0", busy, bus_if.sig_valid);
         err_cnt++;
      end
   endtask

   task automatic test_stop();
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      repeat (2) begin
         @(negedge clk);
         vec_cnt++;
         if (busy !== 1'b0 || bus_if.sig_valid !== 1'b0 || done !== 1'b0) begin
            $display("FAIL stop_start_idle: busy=%b valid=%b done=%b required 0 0 0",
                     busy, bus_if.sig_valid, done);
            err_cnt++;
         end
      end
      $display("stop+start in idle: busy=%b", busy);
      write_word(4'd2, 8'h1C);
      prog_len = 5'd3; bus_if.sig_ready = 1'b1;
      pulse_start();
      repeat (2) @(negedge clk);
      vec_cnt++;
      if (pc !== 4'd1 || bus_if.sig_out !== 8'h42) begin
         $display("FAIL stop_pc1: pc=%0d out=%h required 1 42", pc, bus_if.sig_out);
         err_cnt++;
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      vec_cnt++;
      if (bus_if.sig_valid !== 1'b0 || busy !== 1'b0 || pc !== 4'd0 || done !== 1'b0) begin
         $display("FAIL stop_mid: valid=%b busy=%b pc=%0d done=%b required 0 0 0 0",
                  bus_if.sig_valid, busy, pc, done);
         err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b0) begin
         $display("FAIL stop_no_done: done=%b required 0", done);
         err_cnt++;
      end
      $display("stop   mid-run valid=%b busy=%b", bus_if.sig_valid, busy);
   endtask

   task automatic test_reset_mid_run();
      prog_len = 5'd3; bus_if.sig_ready = 1'b1;
      pulse_start();
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (pc !== 4'd2) begin
         $display("FAIL rst_pc2: pc=%0d required 2", pc);
         err_cnt++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vec_cnt++;
      if ({bus_if.sig_out, bus_if.sig_valid, busy, done, pc, issue_cnt} !== 31'd0) begin
         $display("FAIL rst_mid: out=%h v=%b busy=%b done=%b pc=%0d cnt=%0d required all zero",
                  bus_if.sig_out, bus_if.sig_valid, busy, done, pc, issue_cnt);
         err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL rst_no_done: done=%b busy=%b required 0 0", done, busy);
         err_cnt++;
      end
      $display("rst    mid-run cleared");
   endtask

   task automatic test_zero_len();
      prog_len = 5'd0;
      pulse_start();
      vec_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || bus_if.sig_valid !== 1'b0) begin
         $display("FAIL zero_len: done=%b busy=%b valid=%b required 1 0 0", done, busy, bus_if.sig_valid);
         err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL zero_len_after: done=%b busy=%b required 0 0", done, busy);
         err_cnt++;
      end
      $display("zero   len done pulse seen");
   endtask

   task automatic test_load_while_busy();
      prog_len = 5'd3; bus_if.sig_ready = 1'b0;
      pulse_start();
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 4'd1; ld_data = 8'hFF;
      @(negedge clk);
      ld_en = 1'b0;
      bus_if.sig_ready = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (bus_if.sig_out !== 8'h42 || pc !== 4'd1) begin
         $display("FAIL load_busy: out=%h pc=%0d required 42 1", bus_if.sig_out, pc);
         err_cnt++;
      end
      repeat (2) @(negedge clk);
      vec_cnt++;
      if (done !== 1'b1 || issue_cnt !== 16'd3) begin
         $display("FAIL load_busy_done: done=%b cnt=%0d required 1 3", done, issue_cnt);
         err_cnt++;
      end
      $display("busy   load dropped, out=%h", bus_if.sig_out);
   endtask

   initial begin
      bus_if.sig_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_linear();
      test_alu_gap();
      test_backpressure();
      test_loop();
      test_stop();
      test_reset_mid_run();
      test_zero_len();
      test_load_while_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
